program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, PC/address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter STACK_DEPTH, default 4, return-address stack entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port hold  input  1  freeze PC and stack this cycle.
REQ-007 SHALL have port jump  input  1  load pc from jump_addr.
REQ-008 SHALL have port jump_addr  input  WIDTH  absolute target for jump/call.
REQ-009 SHALL have port branch  input  1  relative branch by offset.
REQ-010 SHALL have port offset  input  8  signed two's-complement branch displacement.
REQ-011 SHALL have port call  input  1  push return address, go to jump_addr.
REQ-012 SHALL have port ret  input  1  pop return address into pc.
REQ-013 SHALL have port pc  output  WIDTH  current program counter, registered.
REQ-014 SHALL have port pc_plus1  output  WIDTH  combinational pc+1 modulo 2^WIDTH.
REQ-015 SHALL have ports stack_full, stack_empty  output  1 each  registered-state status, combinational from stack pointer.
REQ-016 SHALL have port stack_err  output  1  registered one-cycle pulse on overflow/underflow attempt.

Function
REQ-017 SHALL update pc every rising clk edge per the highest-priority active control: hold > call > ret > jump > branch > increment.
REQ-018 SHALL, with all control inputs 0, increment pc by 1 per cycle (free-running counter).
REQ-019 SHALL keep pc, stack and stack pointer unchanged while hold=1; stack_err SHALL be 0 that cycle.
REQ-020 SHALL on call (stack not full) push pc_plus1 and set pc=jump_addr.
REQ-021 SHALL on ret (stack not empty) set pc to the most recently pushed value and pop it (LIFO).
REQ-022 SHALL on jump set pc=jump_addr.
REQ-023 SHALL on branch set pc = pc + sign-extend(offset) modulo 2^WIDTH (offset counted from current pc, not pc+1).
REQ-024 SHALL wrap increment and branch arithmetic: all-ones+1 = 0, 0 + (-1) = all-ones.
REQ-025 SHALL on call with stack full: not push, not jump, increment pc, pulse stack_err next cycle.
REQ-026 SHALL on ret with stack empty: increment pc, pulse stack_err next cycle.
REQ-027 SHALL resolve simultaneous call and ret as call only (ret ignored); lower-priority requests in the same cycle are ignored.
REQ-028 SHALL assert stack_full when entries = STACK_DEPTH, stack_empty when entries = 0.

Reset
REQ-029 SHALL, while reset=0, immediately (asynchronously) force pc=RESET_VECTOR, stack pointer=0 (stack_empty=1, stack_full=0), stack_err=0; stack contents need not be cleared.
REQ-030 SHALL resume counting on the first rising clk edge after reset returns to 1; reset asserted mid-operation SHALL abort any pending call/ret and discard the stack.

Verification
REQ-031 SHALL pass: clk period 10, reset=0 for t=0..10, controls 0 -> pc=00 during reset, then 01,02,03,04,05 on successive edges (t=15..55).
REQ-032 SHALL pass: pc=FE, no controls, two edges -> pc=FF then 00 (wrap).
REQ-033 SHALL pass: pc=10, call jump_addr=40 -> pc=40; two increments -> 42; ret -> pc=11, stack_empty=1.
REQ-034 SHALL pass: four nested calls fill stack (stack_full=1); fifth call -> pc increments, stack_err=1 for exactly one cycle; ret on empty stack likewise pulses stack_err.
REQ-035 SHALL pass: pc=20, branch offset=F0 (-16) -> pc=10; branch offset=05 with hold=1 -> pc stays 10.
REQ-036 SHALL pass: reset driven 0 mid-cycle between edges -> pc=00 without waiting for clk edge.

Source files
------------

// File: rtl/program_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : program_counter_if
//  Description : Control and status bundle between a sequencer and the
//                program counter. The master drives the flow-control
//                requests. The slave (the program counter) returns the PC
//                and the return-stack status.
//  Revision    : 1.0  initial release
// ============================================================================
interface program_counter_if #(
    parameter int unsigned WIDTH = 8
) ();

    // Flow-control requests
    logic             hold;
    logic             jump;
    logic [WIDTH-1:0] jump_addr;
    logic             branch;
    logic [7:0]       offset;
    logic             call;
    logic             ret;

    // Program counter and return-stack status
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus1;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;

    modport master (
        output hold, jump, jump_addr, branch, offset, call, ret,
        input  pc, pc_plus1, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  hold, jump, jump_addr, branch, offset, call, ret,
        output pc, pc_plus1, stack_full, stack_empty, stack_err
    );

endinterface
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
//  Module      : program_counter
//  Description : Program counter with a LIFO return-address stack.
//                The next PC is chosen by priority:
//                hold > call > ret > jump > branch > increment.
//                Stack misuse means a call when the stack is full, or a ret
//                when it is empty. Either one falls back to a plain
//                increment and raises a one-cycle stack_err pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module program_counter #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      STACK_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,   // asynchronous, active low
    program_counter_if.slave   bus
);

    localparam int unsigned      c_ptr_w      = $clog2(STACK_DEPTH);
    localparam logic [c_ptr_w:0] c_sp_one     = {{c_ptr_w{1'b0}}, 1'b1};
    localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w + 1)'(STACK_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   r_pc;
    logic [c_ptr_w:0]   r_sp;          // number of valid stack entries
    logic               r_stack_err;
    logic [WIDTH-1:0]   r_stack [STACK_DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_pc_plus1;
    logic [WIDTH-1:0]   w_offset_ext;
    logic [WIDTH-1:0]   w_branch_target;
    logic [WIDTH-1:0]   w_stack_top;
    logic [c_ptr_w-1:0] w_wr_idx;
    logic [c_ptr_w-1:0] w_top_idx;
    logic               w_full;
    logic               w_empty;

    logic [WIDTH-1:0]   w_pc_next;
    logic [c_ptr_w:0]   w_sp_next;
    logic               w_err_next;
    logic               w_push;

    assign w_pc_plus1      = r_pc + WIDTH'(1);
    assign w_full          = (r_sp == c_full_count);
    assign w_empty         = (r_sp == '0);

    // The write slot is the first free entry. Pushes are only made when
    // the stack is not full, so the count always fits the index width.
    assign w_wr_idx        = r_sp[c_ptr_w-1:0];
    assign w_top_idx       = c_ptr_w'(r_sp - c_sp_one);
    assign w_stack_top     = r_stack[w_top_idx];

    // Sign-extend the 8-bit displacement to the PC width. When the PC is
    // narrower than 8 bits, keep only the low bits. The sum is taken
    // modulo 2^WIDTH, so the upper offset bits cannot affect it.
    if (WIDTH > 8) begin : g_ext_wide
        assign w_offset_ext = {{(WIDTH-8){bus.offset[7]}}, bus.offset};
    end else if (WIDTH == 8) begin : g_ext_equal
        assign w_offset_ext = bus.offset;
    end else begin : g_ext_narrow
        assign w_offset_ext = bus.offset[WIDTH-1:0];
    end

    // The displacement is measured from the current pc, not from pc+1
    assign w_branch_target = r_pc + w_offset_ext;

    // Choose the next pc and stack action using the fixed control priority
    always_comb begin
        w_pc_next  = w_pc_plus1;
        w_sp_next  = r_sp;
        w_err_next = 1'b0;
        w_push     = 1'b0;

        if (bus.hold) begin
            w_pc_next = r_pc;
        end else if (bus.call) begin
            if (w_full) begin
                w_err_next = 1'b1;
            end else begin
                w_push    = 1'b1;
                w_pc_next = bus.jump_addr;
                w_sp_next = r_sp + c_sp_one;
            end
        end else if (bus.ret) begin
            if (w_empty) begin
                w_err_next = 1'b1;
            end else begin
                w_pc_next = w_stack_top;
                w_sp_next = r_sp - c_sp_one;
            end
        end else if (bus.jump) begin
            w_pc_next = bus.jump_addr;
        end else if (bus.branch) begin
            w_pc_next = w_branch_target;
        end
    end

    // PC, stack pointer and error pulse registers, asynchronously reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= RESET_VECTOR;
            r_sp        <= '0;
            r_stack_err <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_sp        <= w_sp_next;
            r_stack_err <= w_err_next;
        end
    end

    // Return-address storage. Its contents are not cleared, because an
    // empty pointer makes every entry unreachable.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_stack[w_wr_idx] <= w_pc_plus1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pc          = r_pc;
    assign bus.pc_plus1    = w_pc_plus1;
    assign bus.stack_full  = w_full;
    assign bus.stack_empty = w_empty;
    assign bus.stack_err   = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_counter
//  Description : Directed bench for program_counter. Expected values are
//                hand-computed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_program_counter;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    program_counter_if #(.WIDTH(8)) bus ();

    program_counter #(
        .WIDTH        (8),
        .RESET_VECTOR (8'h00),
        .STACK_DEPTH  (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply a full set of control inputs
    task automatic drive(input logic h, input logic j, input logic [7:0] ja,
                         input logic b, input logic [7:0] off,
                         input logic c, input logic r);
        bus.hold      = h;
        bus.jump      = j;
        bus.jump_addr = ja;
        bus.branch    = b;
        bus.offset    = off;
        bus.call      = c;
        bus.ret       = r;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Advance one rising edge and sample just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so that the run always ends
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b0;
        idle();

        // Reset state, including across the edge at t=5
        #2;
        check("rst_pc", bus.pc, 8'h00);
        check("rst_empty", bus.stack_empty, 1'b1);
        check("rst_full", bus.stack_full, 1'b0);
        check("rst_err", bus.stack_err, 1'b0);
        #5;
        check("rst_pc_edge", bus.pc, 8'h00);
        #3;
        reset = 1'b1;                         // t = 10

        // Free-running count from the edges at t = 15..55
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("count_%0d", i), bus.pc, i);
        end

        // Wrap at all-ones
        drive(1'b0, 1'b1, 8'hFE, 1'b0, 8'h00, 1'b0, 1'b0);
        step(); idle();
        check("jump_fe", bus.pc, 8'hFE);
        step();
        check("wrap_ff", bus.pc, 8'hFF);
        check("plus1_wrap", bus.pc_plus1, 8'h00);
        step();
        check("wrap_00", bus.pc, 8'h00);

        // Call, then return
        drive(1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0);
        step(); idle();
        check("call_pc", bus.pc, 8'h40);
        check("call_nonempty", bus.stack_empty, 1'b0);
        step(); step();
        check("inc_42", bus.pc, 8'h42);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step(); idle();
        check("ret_pc", bus.pc, 8'h11);
        check("ret_empty", bus.stack_empty, 1'b1);

        // Fill the stack with four nested calls, starting from pc=11
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 8'hA0 + 8'(i * 16), 1'b0, 8'h00, 1'b1, 1'b0);
            step();
        end
        check("fill_pc", bus.pc, 8'hD0);
        check("fill_full", bus.stack_full, 1'b1);
        drive(1'b0, 1'b0, 8'hE0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(); idle();
        check("ovf_pc", bus.pc, 8'hD1);
        check("ovf_err", bus.stack_err, 1'b1);
        check("ovf_full", bus.stack_full, 1'b1);
        step();
        check("ovf_err_clear", bus.stack_err, 1'b0);
        check("ovf_pc2", bus.pc, 8'hD2);

        // Unwind in LIFO order
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step(); check("pop_c1", bus.pc, 8'hC1);
        step(); check("pop_b1", bus.pc, 8'hB1);
        step(); check("pop_a1", bus.pc, 8'hA1);
        step(); check("pop_12", bus.pc, 8'h12);
        check("pop_empty", bus.stack_empty, 1'b1);
        step(); idle();
        check("unf_pc", bus.pc, 8'h13);
        check("unf_err", bus.stack_err, 1'b1);
        step();
        check("unf_err_clear", bus.stack_err, 1'b0);
        check("unf_pc2", bus.pc, 8'h14);

        // call + ret + jump together act as a call only
        drive(1'b0, 1'b1, 8'h60, 1'b0, 8'h00, 1'b1, 1'b1);
        step(); idle();
        check("callret_pc", bus.pc, 8'h60);
        check("callret_nonempty", bus.stack_empty, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step(); idle();
        check("callret_back", bus.pc, 8'h15);

        // ret has priority over jump
        drive(1'b0, 1'b0, 8'h70, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0, 1'b1);
        step(); idle();
        check("ret_over_jump", bus.pc, 8'h16);
        check("ret_over_jump_empty", bus.stack_empty, 1'b1);
        check("plus1", bus.pc_plus1, 8'h17);

        // hold freezes everything and suppresses the error pulse
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step();
        check("hold_ret_pc", bus.pc, 8'h16);
        check("hold_ret_err", bus.stack_err, 1'b0);
        drive(1'b1, 1'b0, 8'h50, 1'b0, 8'h00, 1'b1, 1'b0);
        step(); idle();
        check("hold_call_pc", bus.pc, 8'h16);
        check("hold_call_empty", bus.stack_empty, 1'b1);

        // Branches
        drive(1'b0, 1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'hF0, 1'b0, 1'b0);
        step();
        check("branch_back", bus.pc, 8'h10);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0);
        step();
        check("branch_hold", bus.pc, 8'h10);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0);
        step();
        check("branch_fwd", bus.pc, 8'h15);
        drive(1'b0, 1'b1, 8'h80, 1'b1, 8'h05, 1'b0, 1'b0);
        step();
        check("jump_over_branch", bus.pc, 8'h80);
        drive(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
        step();
        check("branch_0_m1", bus.pc, 8'hFF);
        drive(1'b0, 1'b1, 8'h90, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b0);
        step(); idle();
        check("branch_wrap", bus.pc, 8'h0F);

        // Asynchronous reset between edges discards the stack
        drive(1'b0, 1'b0, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0);
        step(); idle();
        check("pre_areset_pc", bus.pc, 8'h33);
        #2;
        reset = 1'b0;
        #1;
        check("areset_pc", bus.pc, 8'h00);
        check("areset_empty", bus.stack_empty, 1'b1);
        step();
        check("areset_hold", bus.pc, 8'h00);
        #2;
        reset = 1'b1;
        step();
        check("areset_resume", bus.pc, 8'h01);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
